tdc_tap_decoder: RTL and testbench

- Capture end of the TDC delay line: samples the tapped inverter chain on every clk edge and detects the arrival of a hit edge in the line.
- Converts the thermometer snapshot into a fine code and pairs it with a coarse clock-cycle count measured from arm.
- Delivers one timestamp per arm over a valid/ready handshake to the TDC readout logic.

---
 rtl/tdc_pkg.sv | 32 +++
 rtl/tdc_tap_decoder_therm2bin.sv | 46 ++++
 rtl/tdc_tap_decoder.sv | 157 +++++++++++++++
 tb/tb_tdc_tap_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// ============================================================================
// tdc_pkg : shared types and helpers for the TDC tap decoder
// Revision 1.0
// ============================================================================
`default_nettype none

package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DECODE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int c_COARSE_W_MAX = 32;
  localparam int c_FINE_W_MAX   = 8;

  function automatic int fine_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic [c_COARSE_W_MAX-1:0] coarse;
    logic [c_FINE_W_MAX-1:0]   fine;
    logic                      overflow;
    logic                      timeout;
  } result_t;

endpackage

`default_nettype wire

// File: rtl/tdc_tap_decoder_therm2bin.sv
// ============================================================================
// tdc_therm2bin : bubble filter and leading-ones count of a tap snapshot
// Revision 1.0
// ============================================================================
`default_nettype none

module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter  int NUM_TAPS = 32,
  localparam int FINE_W   = fine_width(NUM_TAPS)
) (
  input  logic [NUM_TAPS-1:0] therm_i,
  output logic [FINE_W-1:0]   fine_o
);

  // Pad with a 1 below tap 0 and a 0 above the last tap
  logic [NUM_TAPS+1:0] w_ext;
  logic [NUM_TAPS-1:0] w_filt;
  logic                w_run;
  logic [FINE_W-1:0]   w_count;

  assign w_ext = {1'b0, therm_i, 1'b1};

  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_filter
    assign w_filt[gi] = (w_ext[gi]   & w_ext[gi+1]) |
                        (w_ext[gi]   & w_ext[gi+2]) |
                        (w_ext[gi+1] & w_ext[gi+2]);
  end

  always_comb begin
    w_run   = 1'b1;
    w_count = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_run = w_run & w_filt[i];
      if (w_run) begin
        w_count = w_count + FINE_W'(1);
      end
    end
  end

  assign fine_o = w_count;

endmodule

`default_nettype wire

// File: rtl/tdc_tap_decoder.sv
// ============================================================================
// tdc_tap_decoder : samples the delay line, timestamps one hit per arm
// Revision 1.0
// ============================================================================
`default_nettype none

module tdc_tap_decoder
  import tdc_pkg::*;
#(
  parameter  int NUM_TAPS = 32,
  parameter  int COARSE_W = 16,
  localparam int FINE_W   = fine_width(NUM_TAPS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm_i,
  input  logic [NUM_TAPS-1:0] taps_i,
  output logic                busy_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [COARSE_W-1:0] coarse_o,
  output logic [FINE_W-1:0]   fine_o,
  output logic                overflow_o,
  output logic                timeout_o
);

  localparam logic [COARSE_W-1:0] c_COUNT_MAX = '1;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_TAPS-1:0] r_s1;
  logic [NUM_TAPS-1:0] r_s2;
  logic [NUM_TAPS-1:0] r_snap;
  logic [COARSE_W-1:0] r_count;
  logic                r_qual;
  logic                r_tmo;
  logic                r_busy;
  logic                r_valid;
  result_t             r_res;
  logic                w_hit;
  logic                w_sat;
  logic [FINE_W-1:0]   w_fine;
  logic                w_unused_res;

  tdc_therm2bin #(
    .NUM_TAPS (NUM_TAPS)
  ) u_therm2bin (
    .therm_i (r_snap),
    .fine_o  (w_fine)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    w_sat  = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm_i) begin
          w_next = ARMED;
        end
      end
      ARMED: begin
        // A hit only counts once tap 0 has been seen low since arm
        w_hit = r_qual & r_s2[0];
        w_sat = (r_count == c_COUNT_MAX);
        if (w_hit || w_sat) begin
          w_next = DECODE;
        end
      end
      DECODE: w_next = HOLD;
      HOLD: begin
        if (ready_i) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_snap  <= '0;
      r_count <= '0;
      r_qual  <= 1'b0;
      r_tmo   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_res   <= '0;
    end else begin
      r_s1 <= taps_i;
      r_s2 <= r_s1;
      case (r_state)
        IDLE: begin
          if (arm_i) begin
            r_count <= '0;
            r_qual  <= 1'b0;
            r_tmo   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ARMED: begin
          // The counter freezes on exit and doubles as the coarse latch
          if (!(w_hit || w_sat)) begin
            r_count <= r_count + 1'b1;
          end
          if (!r_s2[0]) begin
            r_qual <= 1'b1;
          end
          if (w_hit) begin
            r_snap <= r_s2;
            r_tmo  <= 1'b0;
          end else if (w_sat) begin
            r_snap <= '0;
            r_tmo  <= 1'b1;
          end
        end
        DECODE: begin
          r_res.coarse   <= c_COARSE_W_MAX'(r_count);
          r_res.fine     <= c_FINE_W_MAX'(w_fine);
          r_res.overflow <= (w_fine == FINE_W'(NUM_TAPS));
          r_res.timeout  <= r_tmo;
          r_valid        <= 1'b1;
        end
        HOLD: begin
          if (ready_i) begin
            r_valid        <= 1'b0;
            r_busy         <= 1'b0;
            r_res.overflow <= 1'b0;
            r_res.timeout  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign valid_o      = r_valid;
  assign coarse_o     = r_res.coarse[COARSE_W-1:0];
  assign fine_o       = r_res.fine[FINE_W-1:0];
  assign overflow_o   = r_res.overflow;
  assign timeout_o    = r_res.timeout;
  assign w_unused_res = ^r_res;

endmodule

`default_nettype wire

// File: tb/tb_tdc_tap_decoder.sv
// ============================================================================
// tb_tdc_tap_decoder : scoreboard bench for tdc_tap_decoder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_tdc_tap_decoder;

  localparam int NT   = 32;
  localparam int CW   = 4;
  localparam int FW   = $clog2(NT + 1);
  localparam int KMAX = (1 << CW) - 1;
  localparam int SEQ  = KMAX + 2;

  typedef logic [NT-1:0] seq_t [SEQ];
  typedef struct packed {
    int vcyc;
    int coarse;
    int fine;
    bit ovf;
    bit tmo;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [NT-1:0] taps_i = '0;
  logic          busy_o;
  logic          valid_o;
  logic [CW-1:0] coarse_o;
  logic [FW-1:0] fine_o;
  logic          overflow_o;
  logic          timeout_o;

  exp_t exq[$];
  exp_t cur;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   pend = 1'b0;

  tdc_tap_decoder #(
    .NUM_TAPS (NT),
    .COARSE_W (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .arm_i      (arm_i),
    .taps_i     (taps_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .coarse_o   (coarse_o),
    .fine_o     (fine_o),
    .overflow_o (overflow_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference: first low-then-high on tap 0 after arm, else timeout at KMAX
  function automatic exp_t model(input seq_t s);
    exp_t          e;
    bit            seen_low;
    bit            done;
    bit            run;
    logic [NT-1:0] snap;
    int            t [NT+2];
    int            votes;
    seen_low = 0; done = 0; snap = '0;
    e.coarse = KMAX; e.vcyc = KMAX; e.tmo = 1;
    for (int k = 0; k <= KMAX; k++) begin
      if (!done) begin
        if (seen_low && s[k][0]) begin
          done = 1; snap = s[k]; e.coarse = k; e.vcyc = k; e.tmo = 0;
        end else if (!s[k][0]) begin
          seen_low = 1;
        end
      end
    end
    t[0] = 1;
    t[NT+1] = 0;
    for (int i = 0; i < NT; i++) t[i+1] = int'(snap[i]);
    e.fine = 0; run = 1;
    for (int i = 0; i < NT; i++) begin
      votes = t[i] + t[i+1] + t[i+2];
      if (run && votes >= 2) e.fine++;
      else run = 0;
    end
    e.ovf = (e.fine == NT);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_seq(output seq_t s);
    for (int k = 0; k < SEQ; k++) s[k] = '0;
  endtask

  task automatic rand_seq(output seq_t s);
    int stale, gap, n, mode, hk;
    logic [NT-1:0] v;
    stale = $urandom_range(0, 3);
    gap   = $urandom_range(1, 13);
    n     = $urandom_range(1, NT);
    mode  = $urandom_range(0, 7);
    for (int k = 0; k < SEQ; k++) s[k] = $urandom;
    for (int k = 0; k < stale; k++) s[k][0] = 1'b1;
    for (int k = stale; k < stale + gap && k < SEQ; k++) s[k][0] = 1'b0;
    hk = stale + gap;
    if (hk < SEQ && mode != 0) begin
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      if (mode == 1) v[$urandom_range(1, NT-1)] ^= 1'b1;
      v[0] = 1'b1;
      s[hk] = v;
    end
  endtask

  // s[k] reaches the second sample stage in the k-th armed cycle
  task automatic run_meas(input seq_t s, input int hold, input bit spur);
    exp_t e;
    int   w;
    e = model(s);
    taps_i = s[0]; ready_i = pend; arm_i = 1'b0;
    tick();
    ready_i = 1'b0; arm_i = 1'b1; taps_i = s[1];
    e.vcyc = cyc + 1 + e.vcyc + 2;
    exq.push_back(e);
    tick();
    arm_i = 1'b0;
    for (int k = 2; k < SEQ; k++) begin
      taps_i = s[k];
      tick();
    end
    taps_i = $urandom;
    w = 0;
    while (!valid_o && w < 20) begin
      tick();
      w++;
    end
    if (!valid_o) chk("valid_wait", 0, 1);
    for (int j = 0; j < hold; j++) begin
      arm_i = spur && (j == hold / 2);
      tick();
    end
    arm_i = 1'b0;
    pend = 1'b1;
  endtask

  task automatic reset_mid_armed();
    if (pend) begin
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      pend = 1'b0;
    end
    taps_i = '0;
    tick();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_coarse", coarse_o, 0);
    chk("rst_fine", fine_o, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: pops one expectation per rising valid, checks hold and release
  initial begin
    bit vprev, hsprev;
    vprev = 0; hsprev = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        vprev = 0; hsprev = 0;
      end else begin
        if (hsprev) begin
          chk("hs_valid_drop", valid_o, 0);
          chk("hs_busy_drop", busy_o, 0);
          chk("hs_ovf_clear", overflow_o, 0);
          chk("hs_tmo_clear", timeout_o, 0);
        end
        if (valid_o && !vprev) begin
          chk("result_expected", exq.size() > 0, 1);
          if (exq.size() > 0) begin
            cur = exq.pop_front();
            chk("latency_cycle", cyc, cur.vcyc);
            chk("coarse", coarse_o, cur.coarse);
            chk("fine", fine_o, cur.fine);
            chk("overflow", overflow_o, cur.ovf);
            chk("timeout", timeout_o, cur.tmo);
            chk("busy_in_result", busy_o, 1);
          end
        end else if (valid_o) begin
          chk("hold_coarse", coarse_o, cur.coarse);
          chk("hold_fine", fine_o, cur.fine);
          chk("hold_overflow", overflow_o, cur.ovf);
          chk("hold_timeout", timeout_o, cur.tmo);
        end
        vprev  = valid_o;
        hsprev = valid_o && ready_i;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1);
  end

  initial begin
    seq_t s;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_coarse", coarse_o, 0);
    chk("reset_fine", fine_o, 0);
    chk("reset_overflow", overflow_o, 0);
    chk("reset_timeout", timeout_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    zero_seq(s); s[6] = 32'h0000_03FF;                  run_meas(s, 10, 1'b1);
    zero_seq(s); s[3] = 32'h0000_02FF;                  run_meas(s, 2, 1'b0);
    zero_seq(s); s[4] = 32'h0010_0007;                  run_meas(s, 1, 1'b0);
    zero_seq(s);
    for (int k = 0; k < SEQ; k++) s[k] = '1;
    s[4] = '0;                                          run_meas(s, 3, 1'b1);
    zero_seq(s);                                        run_meas(s, 0, 1'b0);
    zero_seq(s); s[KMAX] = 32'h0000_0001;               run_meas(s, 2, 1'b0);
    for (int k = 0; k < SEQ; k++) s[k] = '1;            run_meas(s, 1, 1'b0);

    reset_mid_armed();
    zero_seq(s); s[2] = 32'h0000_00FF;                  run_meas(s, 1, 1'b0);

    for (int m = 0; m < 40; m++) begin
      rand_seq(s);
      run_meas(s, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    pend = 1'b0;
    repeat (3) tick();
    chk("queue_drained", exq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
